// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, defaults and error-bit positions for the UART command parser
package uart_pkg;
    typedef enum logic [2:0] {IDLE, GET_OP, GET_LEN, GET_PAY, GET_CHK, WAIT_ACK} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int MAX_LEN_DEF = 16;
    localparam int ERR_OVR = 3;
    localparam int ERR_TMO = 2;
    localparam int ERR_LEN = 1;
    localparam int ERR_CHK = 0;
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: saturating inter-byte timeout counter with clear/enable and expiry flag
module uart_timeout_cnt #(
    parameter int TIMEOUT_CLKS = 208340
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [17:0] LAST = 18'(TIMEOUT_CLKS - 1);
    logic [17:0] cnt;
    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && cnt != LAST) cnt <= cnt + 18'd1;
    // a byte arriving on the expiry cycle clears the count, so it wins
    assign expire = enable && !clear && cnt == LAST;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC/OP/LEN/payload/CHK byte streams into acknowledged commands
module uart_cmd_parser import uart_pkg::*; #(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int TIMEOUT_CLKS = 208340,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Cmd_Ack,
    output logic       o_Cmd_Valid,
    output logic [7:0] o_Cmd_Op,
    output logic [4:0] o_Cmd_Len,
    output logic       o_Pay_Wr_En,
    output logic [3:0] o_Pay_Addr,
    output logic [7:0] o_Pay_Data,
    output logic [3:0] o_Err,
    output logic       o_Busy
);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    state_t state, state_nx;
    logic [7:0] op, op_nx, chk, chk_nx, data_nx;
    logic [4:0] len, len_nx, idx, idx_nx;
    logic [3:0] addr_nx, err_nx;
    logic wr_nx, tmo_exp, in_frame;

    assign in_frame = state != IDLE && state != WAIT_ACK;

    uart_timeout_cnt #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_tmo (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .clear  (i_Rx_DV || !in_frame),
        .enable (in_frame),
        .expire (tmo_exp)
    );

    always_comb begin
        state_nx = state;
        op_nx    = op;
        len_nx   = len;
        idx_nx   = idx;
        chk_nx   = chk;
        wr_nx    = 1'b0;
        addr_nx  = o_Pay_Addr;
        data_nx  = o_Pay_Data;
        err_nx   = '0;
        case (state)
            IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_nx = GET_OP;
            GET_OP: if (i_Rx_DV) begin
                op_nx    = i_Rx_Byte;
                chk_nx   = i_Rx_Byte;
                state_nx = GET_LEN;
            end
            GET_LEN: if (i_Rx_DV) begin
                if (i_Rx_Byte > MAX_B) begin
                    err_nx[ERR_LEN] = 1'b1;
                    state_nx        = IDLE;
                end else begin
                    len_nx   = i_Rx_Byte[4:0];
                    chk_nx   = chk ^ i_Rx_Byte;
                    idx_nx   = '0;
                    state_nx = (i_Rx_Byte == 8'd0) ? GET_CHK : GET_PAY;
                end
            end
            GET_PAY: if (i_Rx_DV) begin
                wr_nx    = 1'b1;
                addr_nx  = idx[3:0];
                data_nx  = i_Rx_Byte;
                chk_nx   = chk ^ i_Rx_Byte;
                idx_nx   = idx + 5'd1;
                state_nx = (idx == len - 5'd1) ? GET_CHK : GET_PAY;
            end
            GET_CHK: if (i_Rx_DV) begin
                err_nx[ERR_CHK] = i_Rx_Byte != chk;
                state_nx        = (i_Rx_Byte == chk) ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                err_nx[ERR_OVR] = i_Rx_DV;
                state_nx        = i_Cmd_Ack ? IDLE : WAIT_ACK;
            end
            default: state_nx = IDLE;
        endcase
        if (tmo_exp) begin
            err_nx[ERR_TMO] = 1'b1;
            state_nx        = IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state       <= IDLE;
            op          <= '0;
            len         <= '0;
            idx         <= '0;
            chk         <= '0;
            o_Pay_Wr_En <= 1'b0;
            o_Pay_Addr  <= '0;
            o_Pay_Data  <= '0;
            o_Err       <= '0;
        end else begin
            state       <= state_nx;
            op          <= op_nx;
            len         <= len_nx;
            idx         <= idx_nx;
            chk         <= chk_nx;
            o_Pay_Wr_En <= wr_nx;
            o_Pay_Addr  <= addr_nx;
            o_Pay_Data  <= data_nx;
            o_Err       <= err_nx;
        end

    assign o_Cmd_Valid = state == WAIT_ACK;
    assign o_Cmd_Op    = op;
    assign o_Cmd_Len   = len;
    assign o_Busy      = state != IDLE;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed self-checking bench for uart_cmd_parser (short timeout for run length)
module tb_uart_cmd_parser;
    localparam int TMO = 64;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ack = 1'b0;
    logic       valid, wr, busy;
    logic [7:0] op, data;
    logic [4:0] len;
    logic [3:0] addr, err;
    int errors = 0;
    int checks = 0;
    int ecnt [4];
    int vcnt = 0;
    int wn = 0;
    logic [3:0] wlog_a [256];
    logic [7:0] wlog_d [256];

    uart_cmd_parser #(.TIMEOUT_CLKS(TMO)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .i_Cmd_Ack(ack), .o_Cmd_Valid(valid), .o_Cmd_Op(op), .o_Cmd_Len(len),
        .o_Pay_Wr_En(wr), .o_Pay_Addr(addr), .o_Pay_Data(data), .o_Err(err), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    initial for (int k = 0; k < 4; k++) ecnt[k] = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (err[k] === 1'b1) ecnt[k] = ecnt[k] + 1;
        if (valid === 1'b1) vcnt = vcnt + 1;
        if (wr === 1'b1) begin
            wlog_a[wn & 255] = addr;
            wlog_d[wn & 255] = data;
            wn = wn + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic ack_cmd();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if ({valid, busy, wr, err} !== 7'd0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {valid, busy, wr, err}); end
        checks++; if ({op, len, addr, data} !== 25'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {op, len, addr, data}); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_valid_frame();
        int w0, e0, e1;
        w0 = wn; e0 = ecnt[0] + ecnt[1] + ecnt[2] + ecnt[3];
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11);
        checks++; if ({wr, addr, data} !== {1'b1, 4'h0, 8'h11}) begin errors++; $display("FAIL pay0_strobe: got %h expected %h", {wr, addr, data}, {1'b1, 4'h0, 8'h11}); end
        send_byte(8'h22); send_byte(8'h21);
        checks++; if ({valid, op, len} !== {1'b1, 8'h10, 5'd2}) begin errors++; $display("FAIL cmd_valid: got %h expected %h", {valid, op, len}, {1'b1, 8'h10, 5'd2}); end
        idle(5);
        checks++; if ({valid, op, len} !== {1'b1, 8'h10, 5'd2}) begin errors++; $display("FAIL cmd_hold: got %h expected %h", {valid, op, len}, {1'b1, 8'h10, 5'd2}); end
        checks++; if (wn - w0 !== 2) begin errors++; $display("FAIL write_count: got %0d expected 2", wn - w0); end
        checks++; if ({wlog_a[w0 & 255], wlog_d[w0 & 255], wlog_a[(w0 + 1) & 255], wlog_d[(w0 + 1) & 255]} !== {4'h0, 8'h11, 4'h1, 8'h22})
            begin errors++; $display("FAIL write_log: got %h expected %h", {wlog_a[w0 & 255], wlog_d[w0 & 255], wlog_a[(w0 + 1) & 255], wlog_d[(w0 + 1) & 255]}, {4'h0, 8'h11, 4'h1, 8'h22}); end
        ack_cmd();
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL ack_release: got %b expected 00", {valid, busy}); end
        idle(2);
        e1 = ecnt[0] + ecnt[1] + ecnt[2] + ecnt[3];
        checks++; if (e1 - e0 !== 0) begin errors++; $display("FAIL good_no_err: got %0d expected 0", e1 - e0); end
    endtask

    task automatic test_bad_chk();
        int v0, c0;
        v0 = vcnt; c0 = ecnt[0];
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
        checks++; if ({err, busy} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL chk_err: got %b expected 00010", {err, busy}); end
        idle(3);
        checks++; if (ecnt[0] - c0 !== 1) begin errors++; $display("FAIL chk_err_once: got %0d expected 1", ecnt[0] - c0); end
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL chk_no_valid: got %0d expected 0", vcnt - v0); end
    endtask

    task automatic test_len();
        int w0, v0;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11);
        checks++; if ({err, busy} !== {4'b0010, 1'b0}) begin errors++; $display("FAIL len_err: got %b expected 00100", {err, busy}); end
        idle(2);
        w0 = wn; v0 = vcnt;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        checks++; if ({valid, op, len} !== {1'b1, 8'h07, 5'd0}) begin errors++; $display("FAIL len0_valid: got %h expected %h", {valid, op, len}, {1'b1, 8'h07, 5'd0}); end
        checks++; if (wn - w0 !== 0) begin errors++; $display("FAIL len0_writes: got %0d expected 0", wn - w0); end
        ack_cmd();
        idle(2);
        w0 = wn;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        ack = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        ack = 1'b0;
        send_byte(8'h11);
        checks++; if ({valid, len} !== {1'b1, 5'd16}) begin errors++; $display("FAIL len16_valid: got %h expected %h", {valid, len}, {1'b1, 5'd16}); end
        checks++; if ({wn - w0, wlog_a[(w0 + 15) & 255], wlog_d[(w0 + 15) & 255]} !== {32'd16, 4'hF, 8'h0F})
            begin errors++; $display("FAIL len16_writes: got %0d/%h/%h expected 16/f/0f", wn - w0, wlog_a[(w0 + 15) & 255], wlog_d[(w0 + 15) & 255]); end
        ack_cmd();
        idle(2);
    endtask

    task automatic test_timeout();
        int t0, seen;
        t0 = ecnt[2]; seen = 0;
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 1; i <= 3 * TMO && seen == 0; i++) begin
            @(negedge clk);
            if (err[2] === 1'b1) seen = i;
        end
        checks++; if (seen !== TMO) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", seen, TMO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %b expected 0", busy); end
        idle(TMO + 5);
        checks++; if (ecnt[2] - t0 !== 1) begin errors++; $display("FAIL tmo_once: got %0d expected 1", ecnt[2] - t0); end
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01); send_byte(8'h33); send_byte(8'h12);
        checks++; if ({valid, op, len} !== {1'b1, 8'h20, 5'd1}) begin errors++; $display("FAIL tmo_recover: got %h expected %h", {valid, op, len}, {1'b1, 8'h20, 5'd1}); end
        ack_cmd();
        idle(2);
        t0 = ecnt[2];
        send_byte(8'hA5); send_byte(8'h10);
        idle(TMO - 2);
        send_byte(8'h01);
        checks++; if ({err, busy} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL byte_wins: got %b expected 00001", {err, busy}); end
        send_byte(8'h44); send_byte(8'h55);
        checks++; if ({valid, op, len} !== {1'b1, 8'h10, 5'd1}) begin errors++; $display("FAIL byte_wins_frame: got %h expected %h", {valid, op, len}, {1'b1, 8'h10, 5'd1}); end
        checks++; if (ecnt[2] - t0 !== 0) begin errors++; $display("FAIL byte_wins_no_tmo: got %0d expected 0", ecnt[2] - t0); end
        ack_cmd();
        idle(2);
    endtask

    task automatic test_overrun();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        idle(3);
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = 8'h55; ack = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0; ack = 1'b0;
        checks++; if ({err, valid, busy} !== {4'b1000, 2'b00}) begin errors++; $display("FAIL overrun: got %b expected 100000", {err, valid, busy}); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int e0, e1;
        e0 = ecnt[0] + ecnt[1] + ecnt[2] + ecnt[3];
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({valid, busy, wr, err, op, len, addr, data} !== 32'd0) begin errors++; $display("FAIL mid_reset_outs: got %h expected 0", {valid, busy, wr, err, op, len, addr, data}); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h10); send_byte(8'h00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_nosync: got %b expected 0", busy); end
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'h30);
        checks++; if ({valid, op, len} !== {1'b1, 8'h30, 5'd0}) begin errors++; $display("FAIL post_reset_frame: got %h expected %h", {valid, op, len}, {1'b1, 8'h30, 5'd0}); end
        ack_cmd();
        idle(2);
        e1 = ecnt[0] + ecnt[1] + ecnt[2] + ecnt[3];
        checks++; if (e1 - e0 !== 0) begin errors++; $display("FAIL mid_reset_no_err: got %0d expected 0", e1 - e0); end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_chk();
        test_len();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
